// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operation sequencer and the processor it drives.
//   - FSM state encodings (2-bit, legacy-compatible constants)
//   - Operation codes OP_ADD / OP_SUB
//   - Default datapath width and register count
package alu_seq_pkg;

  localparam int unsigned DEF_WORDSIZE = 64;
  localparam int unsigned DEF_SIZE     = 32;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;
  localparam logic [1:0] S_WRBACK = 2'd3;

endpackage

// File: rtl/alu_seq_regfile.sv
// SIZE x WORDSIZE register file for the ALU operation sequencer.
// Ports:
//   clk, rst_n            clock, asynchronous active-low clear of all registers
//   we, waddr, wdata      single write port (host or write-back, muxed by caller)
//   raddr1/rdata1         combinational read port (operand A)
//   raddr2/rdata2         combinational read port (operand B)
//   host_raddr/host_rdata registered host read port (1-cycle latency, read-before-write)
module alu_seq_regfile
  import alu_seq_pkg::*;
#(
  parameter int unsigned WORDSIZE = DEF_WORDSIZE,
  parameter int unsigned SIZE     = DEF_SIZE
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(SIZE)-1:0]  waddr,
  input  logic [WORDSIZE-1:0]      wdata,
  input  logic [$clog2(SIZE)-1:0]  raddr1,
  output logic [WORDSIZE-1:0]      rdata1,
  input  logic [$clog2(SIZE)-1:0]  raddr2,
  output logic [WORDSIZE-1:0]      rdata2,
  input  logic [$clog2(SIZE)-1:0]  host_raddr,
  output logic [WORDSIZE-1:0]      host_rdata
);

  logic [WORDSIZE-1:0] mem [SIZE];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SIZE; i++) begin
        mem[i] <= '0;
      end
      host_rdata <= '0;
    end else begin
      if (we) begin
        mem[waddr] <= wdata;
      end
      host_rdata <= mem[host_raddr];
    end
  end

  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU operation sequencer: accepts register-addressed add/sub commands, fetches
// operands from an internal register file, drives the combinational processor
// (num1, num2, operation_in -> result) and writes the result back.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   cmd_valid/cmd_ready                command handshake (ready only in IDLE)
//   cmd_op, cmd_rs1, cmd_rs2, cmd_rd   operation and register addresses
//   wr_en, wr_addr, wr_data            host register write (honoured only in IDLE)
//   rd_addr, rd_data                   registered host read (1-cycle latency)
//   num1, num2, operation_in           operands/operation to the processor
//   result                             processor result
//   done, done_data                    write-back pulse and written value
//   mismatch                           self-check flag with done
// Configuration: define ALU_OP_SEQUENCER_CHECK_EN to enable the result checker;
// otherwise mismatch is tied low.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned WORDSIZE = DEF_WORDSIZE,
  parameter int unsigned SIZE     = DEF_SIZE
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_op,
  input  logic [$clog2(SIZE)-1:0]  cmd_rs1,
  input  logic [$clog2(SIZE)-1:0]  cmd_rs2,
  input  logic [$clog2(SIZE)-1:0]  cmd_rd,
  input  logic                     wr_en,
  input  logic [$clog2(SIZE)-1:0]  wr_addr,
  input  logic [WORDSIZE-1:0]      wr_data,
  input  logic [$clog2(SIZE)-1:0]  rd_addr,
  output logic [WORDSIZE-1:0]      rd_data,
  output logic [WORDSIZE-1:0]      num1,
  output logic [WORDSIZE-1:0]      num2,
  output logic                     operation_in,
  input  logic [WORDSIZE-1:0]      result,
  output logic                     done,
  output logic [WORDSIZE-1:0]      done_data,
  output logic                     mismatch
);

  localparam int unsigned AW = $clog2(SIZE);

  logic [1:0]          state;
  logic                op_q;
  logic [AW-1:0]       rs1_q, rs2_q, rd_q;
  logic [WORDSIZE-1:0] rf_rs1, rf_rs2;
  logic                rf_we;
  logic [AW-1:0]       rf_waddr;
  logic [WORDSIZE-1:0] rf_wdata;

  assign cmd_ready = (state == S_IDLE);

  // Host writes only land in IDLE and write-back only in WRBACK, so one port suffices.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = wr_addr;
    rf_wdata = wr_data;
    if (state == S_WRBACK) begin
      rf_we    = 1'b1;
      rf_waddr = rd_q;
      rf_wdata = result;
    end else if (state == S_IDLE && wr_en) begin
      rf_we = 1'b1;
    end
  end

  alu_seq_regfile #(
    .WORDSIZE (WORDSIZE),
    .SIZE     (SIZE)
  ) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .we         (rf_we),
    .waddr      (rf_waddr),
    .wdata      (rf_wdata),
    .raddr1     (rs1_q),
    .rdata1     (rf_rs1),
    .raddr2     (rs2_q),
    .rdata2     (rf_rs2),
    .host_raddr (rd_addr),
    .host_rdata (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      op_q         <= OP_ADD;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      num1         <= '0;
      num2         <= '0;
      operation_in <= OP_ADD;
      done         <= 1'b0;
      done_data    <= '0;
    end else begin
      done <= (state == S_WRBACK);
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q  <= cmd_op;
            rs1_q <= cmd_rs1;
            rs2_q <= cmd_rs2;
            rd_q  <= cmd_rd;
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          num1         <= rf_rs1;
          num2         <= rf_rs2;
          operation_in <= op_q;
          state        <= S_EXEC;
        end
        S_EXEC: begin
          state <= S_WRBACK;
        end
        S_WRBACK: begin
          done_data <= result;
          state     <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef ALU_OP_SEQUENCER_CHECK_EN
  logic [WORDSIZE-1:0] expected;
  logic                check_fail;
  logic                mismatch_sticky;

  always_comb begin
    expected = (operation_in == OP_SUB) ? num1 - num2 : num1 + num2;
  end

  assign check_fail = (state == S_WRBACK) && (result != expected);

  // mismatch pulses with done; the sticky copy survives until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch        <= 1'b0;
      mismatch_sticky <= 1'b0;
    end else begin
      mismatch        <= check_fail;
      mismatch_sticky <= mismatch_sticky | check_fail;
    end
  end
`else
  assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_op = 1'b0;
  logic [4:0]  cmd_rs1 = '0, cmd_rs2 = '0, cmd_rd = '0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic [4:0]  rd_addr = '0;
  logic [63:0] rd_data;
  logic [63:0] num1, num2;
  logic        operation_in;
  logic [63:0] result;
  logic        done;
  logic [63:0] done_data;
  logic        mismatch;
  logic        corrupt = 1'b0;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [63:0] model [32];
  logic [63:0] sb_q [$];

`ifdef ALU_OP_SEQUENCER_CHECK_EN
  localparam bit CHECK_ON = 1'b1;
`else
  localparam bit CHECK_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  // Behavioural processor: combinational add/sub, optionally corrupted in bit 0.
  assign result = (operation_in ? num1 - num2 : num1 + num2) ^ {63'd0, corrupt};

  alu_op_sequencer #(.WORDSIZE(64), .SIZE(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_rs1      (cmd_rs1),
    .cmd_rs2      (cmd_rs2),
    .cmd_rd       (cmd_rd),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .num1         (num1),
    .num2         (num2),
    .operation_in (operation_in),
    .result       (result),
    .done         (done),
    .done_data    (done_data),
    .mismatch     (mismatch)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] calc(input logic op, input logic [63:0] a, input logic [63:0] b);
    return op ? a - b : a + b;
  endfunction

  // Called at a negedge while idle.
  task automatic host_write(input logic [4:0] a, input logic [63:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    model[a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic host_read(input string tag, input logic [4:0] a, input logic [63:0] exp);
    rd_addr = a;
    @(negedge clk);
    check(tag, rd_data, exp);
  endtask

  // Pushes the expected value at accept; pops and compares when done rises.
  task automatic run_cmd(input string tag, input logic op, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input logic bad_res);
    logic [63:0] e;
    int unsigned cyc;
    check({tag, "_ready"}, {63'd0, cmd_ready}, 64'd1);
    corrupt = bad_res;
    e = calc(op, model[rs1], model[rs2]) ^ {63'd0, bad_res};
    sb_q.push_back(e);
    model[rd] = e;
    cmd_op = op; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_rd = rd; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check({tag, "_busy"}, {63'd0, cmd_ready}, 64'd0);
    cyc = 1;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_lat"}, 64'(cyc), 64'd4);
    check({tag, "_data"}, done_data, (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx);
    check({tag, "_mm"}, {63'd0, mismatch}, {63'd0, CHECK_ON & bad_res});
    corrupt = 1'b0;
  endtask

  initial begin
    int unsigned seen;
    for (int i = 0; i < 32; i++) model[i] = '0;
    repeat (3) @(negedge clk);
    // Reset state
    check("rst_ready", {63'd0, cmd_ready}, 64'd1);
    check("rst_num1", num1, 64'd0);
    check("rst_num2", num2, 64'd0);
    check("rst_op", {63'd0, operation_in}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_ddata", done_data, 64'd0);
    check("rst_mm", {63'd0, mismatch}, 64'd0);
    check("rst_rdata", rd_data, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: basic add
    host_write(5'd1, 64'd5);
    host_write(5'd2, 64'd2);
    run_cmd("t1_add", 1'b0, 5'd1, 5'd2, 5'd3, 1'b0);
    host_read("t1_rd3", 5'd3, 64'd7);

    // 2: add then sub with rd == rs1
    host_write(5'd1, 64'h0000_0000_0005_000A);
    run_cmd("t2_add", 1'b0, 5'd1, 5'd2, 5'd4, 1'b0);
    host_read("t2_rd4a", 5'd4, 64'h0000_0000_0005_000C);
    run_cmd("t2_sub", 1'b1, 5'd4, 5'd2, 5'd4, 1'b0);
    host_read("t2_rd4b", 5'd4, 64'h0000_0000_0005_000A);

    // 3: carries across 32-bit boundary and wrapping subtraction
    host_write(5'd1, 64'h0000_0000_0001_0005);
    host_write(5'd2, 64'h0000_0002_0000_0000);
    run_cmd("t3_add", 1'b0, 5'd1, 5'd2, 5'd5, 1'b0);
    host_read("t3_rd5", 5'd5, 64'h0000_0002_0001_0005);
    run_cmd("t3_sub", 1'b1, 5'd2, 5'd1, 5'd6, 1'b0);
    host_read("t3_rd6", 5'd6, 64'h0000_0001_FFFE_FFFB);

    // 3b: same-cycle host write and accept; rs1 == rs2
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'h1234; model[7] = 64'h1234;
    run_cmd("t3_wrcmd", 1'b0, 5'd7, 5'd7, 5'd8, 1'b0);
    wr_en = 1'b0;
    host_read("t3_rd8", 5'd8, 64'h2468);

    // 4: cmd_valid held for three commands; host write in FETCH is dropped
    cmd_valid = 1'b1;
    for (int unsigned c = 0; c <= 12; c++) begin
      if (c > 0 && c % 4 == 0) begin
        check("t4_done", {63'd0, done}, 64'd1);
        check("t4_data", done_data, (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx);
      end
      if (c == 12) begin
        cmd_valid = 1'b0;
      end else if (c % 4 == 0) begin
        check("t4_ready", {63'd0, cmd_ready}, 64'd1);
        cmd_op  = c[2];
        cmd_rs1 = 5'd5;
        cmd_rs2 = (c == 8) ? 5'd9 : 5'd1;
        cmd_rd  = 5'd9 + 5'(c / 4);
        sb_q.push_back(calc(cmd_op, model[cmd_rs1], model[cmd_rs2]));
        model[cmd_rd] = calc(cmd_op, model[cmd_rs1], model[cmd_rs2]);
      end else begin
        check("t4_busy", {63'd0, cmd_ready}, 64'd0);
      end
      if (c == 1) begin
        wr_en = 1'b1; wr_addr = 5'd20; wr_data = 64'hDEAD_BEEF;
      end
      if (c == 2) wr_en = 1'b0;
      @(negedge clk);
    end
    check("t4_nodone", {63'd0, done}, 64'd0);
    host_read("t4_drop", 5'd20, 64'd0);
    host_read("t4_rd11", 5'd11, model[11]);

    // 5: reset during EXEC aborts the command
    host_write(5'd21, 64'd40);
    cmd_op = 1'b0; cmd_rs1 = 5'd21; cmd_rs2 = 5'd21; cmd_rd = 5'd22; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_num1", num1, 64'd0);
    check("t5_ready", {63'd0, cmd_ready}, 64'd1);
    check("t5_ddata", done_data, 64'd0);
    for (int i = 0; i < 32; i++) model[i] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("t5_nodone", 64'(seen), 64'd0);
    host_read("t5_rd22", 5'd22, 64'd0);
    host_write(5'd21, 64'd11);
    run_cmd("t5_after", 1'b0, 5'd21, 5'd21, 5'd22, 1'b0);
    host_read("t5_rd22b", 5'd22, 64'd22);

    // 6: result checker (mismatch only when the checker is built in)
    run_cmd("t6_bad", 1'b1, 5'd22, 5'd21, 5'd23, 1'b1);
    @(negedge clk);
    check("t6_mmclr", {63'd0, mismatch}, 64'd0);
    run_cmd("t6_good", 1'b1, 5'd22, 5'd21, 5'd24, 1'b0);

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Synthesizable initiator for the `processor` add/sub datapath (num1, num2, operation_in → result).
- Accepts register-addressed commands and reads two operands from an internal SIZE x WORDSIZE register file.
- Drives the operands and operation to the processor, captures its result and writes it back to the register file.
- Sits between host/control logic and the processor, replacing the stimulus role the bench plays today.

Parameters:
- WORDSIZE, 64, operand/result width.
- SIZE, 32, number of registers; address width is log2(SIZE) = 5.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  1  0 = add, 1 = subtract; forwarded as operation_in.
- cmd_rs1  in  5  source register for num1.
- cmd_rs2  in  5  source register for num2.
- cmd_rd  in  5  destination register.
- wr_en  in  1  host register write.
- wr_addr  in  5  host write address.
- wr_data  in  WORDSIZE  host write data.
- rd_addr  in  5  host read address.
- rd_data  out  WORDSIZE  registered read data.
- num1  out  WORDSIZE  operand A to processor.
- num2  out  WORDSIZE  operand B to processor.
- operation_in  out  1  operation to processor.
- result  in  WORDSIZE  processor result, combinational from num1/num2.
- done  out  1  one-cycle pulse: write-back completed.
- done_data  out  WORDSIZE  value written at the last write-back.
- mismatch  out  1  self-check flag; see Optional Feature.

Behaviour:
- Reset (async, rst_n = 0) puts the block in this state:
  - state = IDLE, cmd_ready = 1.
  - num1, num2, operation_in, done, done_data, mismatch, rd_data = 0.
  - All registers = 0.
- Reset asserted mid-operation aborts the command; no write-back occurs.
- FSM states are IDLE, FETCH, EXEC, WRBACK.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready, latch cmd_op, cmd_rs1, cmd_rs2, cmd_rd and go to FETCH.
- FETCH:
  - num1 <= rf[rs1], num2 <= rf[rs2], operation_in <= op.
  - Go to EXEC.
- EXEC: outputs held stable for the processor's combinational settle; go to WRBACK.
- WRBACK:
  - rf[rd] <= result, done_data <= result.
  - done <= 1 (visible the following cycle, together with IDLE).
  - Go to IDLE.
- Timing: accept at edge 0 → done high in cycle 4; cmd_ready low in cycles 1-3.
- Throughput: one command per 4 cycles; back-to-back accept is allowed in the done cycle.
- num1, num2 and operation_in hold their last values while IDLE; they are not cleared after a command.
- rs1 == rs2 is legal. rd may equal rs1 or rs2; operands are already latched, so the write-back has no hazard.
- Host write:
  - Effective only in IDLE; dropped silently in other states.
  - A host write and a command accept in the same IDLE cycle are both performed. FETCH, one cycle later, sees the new value.
- rd_data <= rf[rd_addr] every cycle (1-cycle latency).
  - A read of an address being written that same cycle returns the old value.
- Arithmetic is performed solely by the processor and is modulo 2^WORDSIZE. The sequencer never alters result.
- All addresses are 5 bits; no out-of-range case exists for SIZE = 32.

Optional Feature:
- Macro: ALU_OP_SEQUENCER_CHECK_EN.
- Defined:
  - In WRBACK, compute expected = op ? num1 - num2 : num1 + num2 (mod 2^WORDSIZE).
  - mismatch <= (result != expected), pulsed with done.
  - mismatch is sticky in a separate internal flag that only reset clears. The mismatch output itself follows done.
- Undefined: mismatch tied 0; no comparator logic synthesized.

Decomposition:
- Shared package/include alu_seq_pkg holds:
  - FSM state encodings (2-bit localparams).
  - OP_ADD = 0, OP_SUB = 1.
  - Default WORDSIZE/SIZE constants, so the processor and this block agree.
- Sub-module alu_seq_regfile covers the register file:
  - SIZE x WORDSIZE, async clear.
  - One write port muxed between host and write-back, with the FSM guaranteeing exclusivity.
  - Two combinational read ports (rs1, rs2) plus one registered host read port.
- Top level holds the FSM, the operand registers and the check logic.

Test Plan:
1. Host-write r1=5, r2=2; cmd add rs1=1 rs2=2 rd=3 → done in cycle 4 after accept, done_data=7, rd_addr=3 gives rd_data=7.
2. r1=0x0000_0000_0005_000A, r2=2, add rd=4 → done_data=0x0000_0000_0005_000C. Then cmd sub rs1=4 rs2=2 rd=4 → 0x0000_0000_0005_000A (rd==rs1).
3. r1=0x0000_0000_0001_0005, r2=0x0000_0002_0000_0000, add → 0x0000_0002_0001_0005. Sub of r2 - r1 wraps to 0x0000_0001_FFFE_FFFB.
4. cmd_valid held high for 3 commands → accepts exactly at cycles 0, 4, 8; cmd_ready low in between; a host write issued during FETCH is dropped (readback unchanged).
5. Assert rst_n low during EXEC → outputs 0 asynchronously, rd register stays 0, no done pulse; the next command after release completes normally.
6. With ALU_OP_SEQUENCER_CHECK_EN, bench forces result = expected ^ 1 → mismatch=1 with done. With the correct result → 0. Without the macro → mismatch always 0.
